// File: rtl/vm1_timer_resp.sv
// vm1_timer_resp: 1801VM1 data-bus responder with a prescaled 16-bit down-counter timer
module vm1_timer_resp #(
    parameter logic [15:0] BASE = 16'o177706
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] dba,
    input  logic [15:0] dbo,
    input  logic        din,
    input  logic        dout,
    input  logic        wtbt,
    output logic [15:0] dbi_o,
    output logic        rply,
    output logic        irq
);
    localparam logic [15:0] CNT_ADDR = BASE + 16'd2;
    localparam logic [15:0] CTL_ADDR = BASE + 16'd4;
    typedef enum logic {IDLE, ACK} state_t;
    state_t      state;
    logic        rd_act;
    logic [15:0] reload, count, rdata, count_t;
    logic [7:0]  prescaler;
    logic [1:0]  ps;
    logic        run, oneshot, ie, exp;
    logic        sel_rld, sel_cnt, sel_ctl, hit, start, wr, we_lo, we_hi, wr_ctl;
    logic        tick, zero, run_t, exp_set, load;
    assign sel_rld = dba[15:1] == BASE[15:1];
    assign sel_cnt = dba[15:1] == CNT_ADDR[15:1];
    assign sel_ctl = dba[15:1] == CTL_ADDR[15:1];
    assign hit     = sel_rld | sel_cnt | sel_ctl;
    assign start   = ce && state == IDLE && hit && (din ^ dout);
    assign wr      = start && dout;
    assign we_lo   = !wtbt || !dba[0];
    assign we_hi   = !wtbt || dba[0];
    assign wr_ctl  = wr && sel_ctl && we_lo;
    assign rdata   = sel_rld ? reload : sel_cnt ? count : {8'h00, exp, 2'b00, ps, ie, oneshot, run};
    assign irq     = ie & exp;
    assign tick    = run && (ps == 2'b00 || (ps == 2'b01 && &prescaler[3:0]) ||
                     (ps == 2'b10 && &prescaler[5:0]) || (ps == 2'b11 && &prescaler));
    assign zero    = count == 16'd0;
    assign count_t = !tick ? count : !zero ? count - 16'd1 : oneshot ? count : reload;
    assign run_t   = run && !(tick && zero && oneshot);
    assign exp_set = tick && zero;
    // a RUN=1 write reloads whenever the timer would otherwise be stopped after this cycle
    assign load    = wr_ctl && dbo[0] && !run_t;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rd_act <= 1'b0;
            rply   <= 1'b0;
            dbi_o  <= 16'h0000;
        end else if (ce) begin
            if (state == IDLE) begin
                if (start) begin
                    state  <= ACK;
                    rd_act <= din;
                    rply   <= 1'b1;
                    dbi_o  <= din ? rdata : 16'h0000;
                end
            end else if (!(rd_act ? din : dout)) begin
                state <= IDLE;
                rply  <= 1'b0;
                dbi_o <= 16'h0000;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload    <= 16'h0000;
            count     <= 16'h0000;
            prescaler <= 8'h00;
            ps        <= 2'b00;
            run       <= 1'b0;
            oneshot   <= 1'b0;
            ie        <= 1'b0;
            exp       <= 1'b0;
        end else if (ce) begin
            prescaler <= load ? 8'h00 : run ? prescaler + 8'd1 : prescaler;
            count     <= load ? reload : count_t;
            run       <= wr_ctl ? dbo[0] : run_t;
            exp       <= exp_set || (exp && !(wr_ctl && !dbo[7]));
            if (wr_ctl) {ps, ie, oneshot} <= dbo[4:1];
            if (wr && sel_rld && we_lo) reload[7:0] <= dbo[7:0];
            if (wr && sel_rld && we_hi) reload[15:8] <= dbo[15:8];
        end
    end
endmodule

// File: tb/tb_vm1_timer_resp.sv
// tb_vm1_timer_resp: scoreboard bench for the vm1_timer_resp bus responder and timer
module tb_vm1_timer_resp;
    localparam logic [15:0] A_RLD = 16'o177706, A_CNT = 16'o177710, A_CTL = 16'o177712;
    logic clk = 1'b0, reset_n = 1'b0, ce = 1'b1, din = 1'b0, dout = 1'b0, wtbt = 1'b0;
    logic [15:0] dba = 16'h0000, dbo = 16'h0000, dbi_o;
    logic rply, irq;
    int checks = 0, failures = 0, cyc = 0;
    logic [15:0] sb[$];

    vm1_timer_resp dut (.clk(clk), .reset_n(reset_n), .ce(ce), .dba(dba), .dbo(dbo), .din(din),
                        .dout(dout), .wtbt(wtbt), .dbi_o(dbi_o), .rply(rply), .irq(irq));

    always #5 clk = ~clk;
    always @(posedge clk) if (ce) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // timer state sampled at commit edge e, timer started (loaded) at edge s
    function automatic logic [15:0] m_cnt(int r, int div, int s, int e, bit os);
        int t = (e - 1 - s) / div;
        return os ? (t >= r ? 16'd0 : 16'(r - t)) : 16'(r - t % (r + 1));
    endfunction

    function automatic logic [7:0] m_ctl(int r, int div, int s, int e, bit os, logic [7:0] cfg);
        int t = (e - 1 - s) / div;
        return {t > r, 2'b00, cfg[4:1], !(os && t > r)};
    endfunction

    // one handshake; called just after a negedge, returns just after a negedge
    task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic w, input logic bw,
                       input int hold, output logic [15:0] rdat, output int ccyc,
                       output logic stable, output logic rel_ok);
        int n = 0;
        dba = a; dbo = d; wtbt = bw; dout = w; din = !w;
        do begin @(negedge clk); n++; end while (!rply && n < 8);
        ccyc = rply ? cyc : -1;
        rdat = dbi_o;
        stable = 1'b1;
        repeat (hold) begin @(negedge clk); stable &= rply && dbi_o === rdat; end
        din = 1'b0; dout = 1'b0;
        @(negedge clk);
        rel_ok = !rply && dbi_o === 16'h0000;
    endtask

    task automatic test_reset;
        logic [15:0] rd, x; int cc, e; logic st, ro;
        logic [15:0] addrs [3] = '{A_RLD, A_CNT, A_CTL};
        repeat (2) @(negedge clk);
        checks++;
        if (rply !== 1'b0 || dbi_o !== 16'h0000 || irq !== 1'b0) begin
            failures++; $display("FAIL reset_outputs rply=%b dbi_o=%h irq=%b required 0/0000/0", rply, dbi_o, irq);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = cyc + 1;
            sb.push_back(16'h0000);
            bus(addrs[i], 16'h0, 1'b0, 1'b0, 0, rd, cc, st, ro);
            x = sb.pop_front();
            checks++;
            if (rd !== x || cc != e || !ro) begin
                failures++; $display("FAIL reset_read[%0d] data=%h required=%h commit=%0d required=%0d rel_ok=%b", i, rd, x, cc, e, ro);
            end
        end
    endtask

    task automatic test_rw;
        logic [15:0] rd, x; int cc, e; logic st, ro;
        for (int i = 0; i < 2; i++) begin
            e = cyc + 1;
            sb.push_back(i == 0 ? 16'h0000 : 16'o000005);
            bus(A_RLD, 16'o000005, i == 0, 1'b0, i * 3, rd, cc, st, ro);
            x = sb.pop_front();
            checks++;
            if (rd !== x || cc != e || !st || !ro) begin
                failures++; $display("FAIL rw[%0d] data=%h required=%h commit=%0d required=%0d stable=%b rel_ok=%b", i, rd, x, cc, e, st, ro);
            end
        end
    endtask

    task automatic test_byte_write;
        logic [15:0] rd, x; int cc, e; logic st, ro;
        logic [15:0] a  [9] = '{A_RLD, 16'o177707, A_RLD, 16'o177706, A_RLD, A_CNT, A_CNT, 16'o177713, A_CTL};
        logic [15:0] d  [9] = '{16'h1234, 16'hABAB, 16'h0, 16'hCDCD, 16'h0, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0};
        logic        w  [9] = '{1, 1, 0, 1, 0, 1, 0, 1, 0};
        logic        bw [9] = '{0, 1, 0, 1, 0, 0, 0, 1, 0};
        logic [15:0] r  [9] = '{16'h0, 16'h0, 16'hAB34, 16'h0, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0};
        for (int i = 0; i < 9; i++) begin
            e = cyc + 1;
            sb.push_back(r[i]);
            bus(a[i], d[i], w[i], bw[i], 0, rd, cc, st, ro);
            x = sb.pop_front();
            checks++;
            if (rd !== x || cc != e || !ro) begin
                failures++; $display("FAIL byte[%0d] data=%h required=%h commit=%0d required=%0d rel_ok=%b", i, rd, x, cc, e, ro);
            end
        end
    endtask

    task automatic test_timer(input int r, input int div, input logic [7:0] cfg, input int n, input string name);
        logic [15:0] rd, x; int cc, e, s; logic st, ro;
        bus(A_CTL, 16'h0, 1'b1, 1'b0, 0, rd, cc, st, ro);
        bus(A_RLD, 16'(r), 1'b1, 1'b0, 0, rd, cc, st, ro);
        e = cyc + 1;
        bus(A_CTL, {8'h00, cfg}, 1'b1, 1'b0, 0, rd, s, st, ro);
        checks++;
        if (s != e || !ro) begin
            failures++; $display("FAIL %s_start commit=%0d required=%0d rel_ok=%b", name, s, e, ro);
        end
        for (int i = 0; i < n; i++) begin
            if (i == 5) begin ce = 1'b0; repeat (7) @(negedge clk); ce = 1'b1; end
            e = cyc + 1;
            sb.push_back(i[0] ? {8'h00, m_ctl(r, div, s, e, cfg[1], cfg)} : m_cnt(r, div, s, e, cfg[1]));
            bus(i[0] ? A_CTL : A_CNT, 16'h0, 1'b0, 1'b0, i % 4, rd, cc, st, ro);
            x = sb.pop_front();
            checks++;
            if (rd !== x || cc != e || !st || !ro) begin
                failures++; $display("FAIL %s[%0d] data=%h required=%h commit=%0d required=%0d stable=%b rel_ok=%b", name, i, rd, x, cc, e, st, ro);
            end
        end
        x = {8'h00, m_ctl(r, div, s, cyc + 1, cfg[1], cfg)};
        checks++;
        if (irq !== (x[7] & cfg[2])) begin
            failures++; $display("FAIL %s_irq irq=%b required=%b", name, irq, x[7] & cfg[2]);
        end
    endtask

    task automatic test_irq_clear;
        logic [15:0] rd, x; int cc, e; logic st, ro;
        bus(A_CTL, 16'o000004, 1'b1, 1'b0, 0, rd, cc, st, ro);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear irq=%b required=0", irq); end
        e = cyc + 1;
        sb.push_back(16'h0004);
        bus(A_CTL, 16'h0, 1'b0, 1'b0, 0, rd, cc, st, ro);
        x = sb.pop_front();
        checks++;
        if (rd !== x || cc != e) begin
            failures++; $display("FAIL irq_clear_ctl data=%h required=%h commit=%0d required=%0d", rd, x, cc, e);
        end
    endtask

    task automatic test_no_ack;
        logic [15:0] rd, x; int cc, e; logic st, ro, seen;
        logic [15:0] miss [3] = '{16'o177714, 16'o177704, 16'o177714};
        bus(A_RLD, 16'h0F0F, 1'b1, 1'b0, 0, rd, cc, st, ro);
        for (int i = 0; i < 3; i++) begin
            bus(miss[i], 16'hFFFF, i == 2, 1'b0, 0, rd, cc, st, ro);
            checks++;
            if (cc != -1 || rd !== 16'h0000) begin
                failures++; $display("FAIL miss[%0d] commit=%0d required=-1 data=%h", i, cc, rd);
            end
        end
        dba = A_RLD; dbo = 16'hFFFF; wtbt = 1'b0; din = 1'b1; dout = 1'b1; seen = 1'b0;
        repeat (6) begin @(negedge clk); seen |= rply; end
        din = 1'b0; dout = 1'b0;
        @(negedge clk);
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL both_strobes rply_seen=%b required=0", seen); end
        e = cyc + 1;
        sb.push_back(16'h0F0F);
        bus(A_RLD, 16'h0, 1'b0, 1'b0, 0, rd, cc, st, ro);
        x = sb.pop_front();
        checks++;
        if (rd !== x || cc != e) begin
            failures++; $display("FAIL no_change data=%h required=%h commit=%0d required=%0d", rd, x, cc, e);
        end
    endtask

    task automatic test_reset_in_ack;
        logic [15:0] rd, x; int cc, e, n; logic st, ro;
        dba = A_RLD; din = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!rply && n < 8);
        checks++;
        if (rply !== 1'b1) begin failures++; $display("FAIL ack_before_reset rply=%b required=1", rply); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (rply !== 1'b0 || dbi_o !== 16'h0000) begin
            failures++; $display("FAIL reset_in_ack rply=%b dbi_o=%h required 0/0000", rply, dbi_o);
        end
        @(negedge clk);
        din = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        e = cyc + 1;
        sb.push_back(16'h0000);
        bus(A_RLD, 16'h0, 1'b0, 1'b0, 0, rd, cc, st, ro);
        x = sb.pop_front();
        checks++;
        if (rd !== x || cc != e || !ro) begin
            failures++; $display("FAIL reissue data=%h required=%h commit=%0d required=%0d rel_ok=%b", rd, x, cc, e, ro);
        end
    endtask

    initial begin
        test_reset;
        test_rw;
        test_byte_write;
        test_timer(3, 1, 8'h01, 12, "cont");
        test_timer(2, 1, 8'h07, 8, "oneshot");
        test_irq_clear;
        test_timer(1, 16, 8'h09, 18, "ps16");
        test_no_ack;
        test_reset_in_ack;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vm1_timer_resp.md
Name: vm1_timer_resp

Overview:
- Bus responder for the 1801VM1 soft CPU's data-bus interface: it decodes the CPU's address and strobes, returns read data, and asserts reply.
- Contains a programmable 16-bit down-counter timer with prescaler, sticky expiry flag and interrupt request.
- Occupies three word registers on the system bus at BASE: RELOAD, COUNT and CONTROL.

Parameters:
- BASE, 16'o177706, word address of RELOAD; COUNT is at BASE+2, CONTROL at BASE+4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- ce  in  1  clock enable; all state advances only when ce=1
- dba  in  16  bus address from CPU
- dbo  in  16  write data from CPU
- din  in  1  read strobe, held by CPU until rply
- dout  in  1  write strobe, held by CPU until rply
- wtbt  in  1  byte write; dba[0] selects the byte (0=low, 1=high)
- dbi_o  out  16  read data; 0 when not replying to a read
- rply  out  1  transaction acknowledge
- irq  out  1  interrupt request (CTRL.IE & CTRL.EXP)

Behaviour:
- Reset (asynchronous): RELOAD=0, COUNT=0, CONTROL=0, prescaler=0, rply=0, dbi_o=0, irq=0, FSM=IDLE.
- Address decode uses dba[15:1]. A hit is BASE, BASE+2 or BASE+4; any other address is a miss, and a miss is never acknowledged.
- FSM IDLE: on a ce cycle with a hit and exactly one of din/dout high, go to ACK.
  - A write commits in that same cycle.
  - Read data is captured into dbi_o in that same cycle.
  - rply goes to 1 on the following clk edge, i.e. one ce cycle of latency.
  - din and dout both high: no action, stay in IDLE.
- FSM ACK: rply=1 and dbi_o is held stable.
  - When the active strobe drops, return to IDLE with rply=0 and dbi_o=0.
  - A new transaction therefore needs the strobe to go low first.
  - Each transaction commits exactly once, regardless of how long the strobe is held.
- Read values:
  - RELOAD: full 16 bits.
  - COUNT: live value sampled at the commit cycle.
  - CONTROL: bits[7:0]; bits[15:8] read as 0.
- Write rules:
  - Word write replaces 16 bits. Byte write replaces only the selected byte.
  - Writes to COUNT are acknowledged but ignored.
  - A write to CONTROL's high byte is acknowledged and has no effect.
- CONTROL bits:
  - [0] RUN: counter enable.
  - [1] ONESHOT: stop at expiry.
  - [2] IE: interrupt enable.
  - [4:3] PS: prescaler select; 00=/1, 01=/16, 10=/64, 11=/256.
  - [7] EXP: sticky expiry flag. Writing 0 clears it; writing 1 has no effect.
  - [6:5]: read as 0.
- RUN 0->1 via write: COUNT<=RELOAD and prescaler<=0 in the commit cycle; no tick occurs in that cycle.
  - Writing RUN=1 while already running does not reload.
  - Clearing RUN freezes COUNT.
- Prescaler: 8-bit counter, increments on each ce cycle while RUN=1.
  - tick = (PS==00) or (prescaler low log2(div) bits all 1).
  - Changing PS takes effect immediately and does not clear the prescaler.
- On a tick:
  - COUNT!=0: COUNT<=COUNT-1.
  - COUNT==0, continuous mode: COUNT<=RELOAD and EXP<=1. The period is therefore RELOAD+1 ticks.
  - COUNT==0, ONESHOT=1: EXP<=1, RUN<=0, COUNT stays 0.
- Simultaneous events in the same cycle:
  - EXP set by the timer and EXP cleared by a bus write: set wins.
  - RUN cleared by ONESHOT expiry and a bus write of RUN=1: the bus write wins, including the reload.
  - RELOAD write and reload event: the old RELOAD value is used.
- irq is combinational from the registered CONTROL bits and is deasserted as soon as EXP or IE clears.
- reset_n asserted mid-transaction forces IDLE with rply=0. The CPU must re-issue the transaction.
- ce=0: FSM, timer and prescaler all hold; outputs hold.

Test Plan:
- Word write 16'o000005 to 16'o177706, then read it back -> rply is high one ce cycle after each strobe, deasserts after strobe release, read returns 16'o000005; dbi_o=0 outside rply.
- RELOAD=3, write CONTROL=16'o000001 (PS=/1) -> COUNT reads 3,2,1,0 on consecutive cycles, then 3 with EXP=1; EXP sets again every 4 cycles.
- RELOAD=2, CONTROL=16'o000007 (oneshot, IE) -> after 3 ticks COUNT=0, RUN=0, EXP=1, irq=1; writing CONTROL=16'o000004 clears EXP and drops irq.
- PS=01, RELOAD=1 -> COUNT decrements once per 16 ce cycles; EXP sets 32 cycles after start.
- Byte write 8'hAB with dba=16'o177707, wtbt=1 -> RELOAD high byte=8'hAB, low byte unchanged; write to COUNT is acknowledged and COUNT is unaffected.
- Strobe to 16'o177714, din+dout together, or reset_n pulsed during ACK -> no rply (reset case: rply=0 immediately) and no register changes.
